block_average_scaler: RTL and testbench

Parametrised frame downscaler that shrinks a stored image by 2x2 or 4x4 block averaging, selectable per frame. It sits between the source frame buffer and the destination buffer. It issues its own pipelined single-port reads, accumulates each block, and writes one averaged pixel per block in raster order. A start/busy/done handshake lets the control FSM chain it with other frame-processing passes.

---
 rtl/block_average_scaler_if.sv | 31 +++
 rtl/block_average_scaler.sv | 216 +++++++++++++++++++++
 tb/tb_block_average_scaler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/block_average_scaler_if.sv
`default_nettype none
// ============================================================================
// block_average_scaler_if: control handshake plus source/destination buffer ports.
// Revision: 1.0
// ============================================================================
interface block_average_scaler_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
);
  logic              start;
  logic              factor_sel;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  start, factor_sel, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, factor_sel, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/block_average_scaler.sv
`default_nettype none
// ============================================================================
// block_average_scaler: 2x2 / 4x4 block-average frame downscaler.
// Revision: 1.0
// ============================================================================
module block_average_scaler #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  block_average_scaler_if.master bus
);

  generate
    if ((IMG_W % 4) != 0) begin : g_chk_img_w
      $error("IMG_W must be a multiple of 4");
    end
    if ((IMG_H % 4) != 0) begin : g_chk_img_h
      $error("IMG_H must be a multiple of 4");
    end
    if ((64'd1 << ADDR_W) < (64'(IMG_W) * 64'(IMG_H))) begin : g_chk_addr_w
      $error("ADDR_W too narrow for IMG_W*IMG_H");
    end
  endgenerate

  // Address steps: within-block row wrap and block-row wrap, per factor
  localparam logic [ADDR_W-1:0] c_row_step2  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] c_row_step4  = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] c_brow_step2 = ADDR_W'(IMG_W + 2);
  localparam logic [ADDR_W-1:0] c_brow_step4 = ADDR_W'(3 * IMG_W + 4);
  localparam logic [ADDR_W-1:0] c_ow2_m1     = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0] c_ow4_m1     = ADDR_W'(IMG_W / 4 - 1);
  localparam logic [ADDR_W-1:0] c_n2_m1      = ADDR_W'((IMG_W * IMG_H) / 4 - 1);
  localparam logic [ADDR_W-1:0] c_n4_m1      = ADDR_W'((IMG_W * IMG_H) / 16 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_f4, w_f4_nxt;
  logic [1:0]        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic [ADDR_W-1:0] r_bx, w_bx_nxt;
  logic [ADDR_W-1:0] r_blk, w_blk_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [PIX_W-1:0]  r_wr_data, w_wr_data_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_rd_vld;
  logic [PIX_W+3:0]  r_acc, w_acc_sum;
  logic              w_acc_clr;

  logic [1:0]        w_fm1;
  logic [ADDR_W-1:0] w_row_step, w_brow_step, w_f_step, w_ow_m1, w_last_blk;

  assign w_fm1       = r_f4 ? 2'd3 : 2'd1;
  assign w_row_step  = r_f4 ? c_row_step4 : c_row_step2;
  assign w_brow_step = r_f4 ? c_brow_step4 : c_brow_step2;
  assign w_f_step    = r_f4 ? ADDR_W'(4) : ADDR_W'(2);
  assign w_ow_m1     = r_f4 ? c_ow4_m1 : c_ow2_m1;
  assign w_last_blk  = r_f4 ? c_n4_m1 : c_n2_m1;

  // Read data returns one cycle after its strobe
  assign w_acc_sum = r_acc + (r_rd_vld ? {4'd0, bus.rd_data} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_f4_nxt      = r_f4;
    w_dx_nxt      = r_dx;
    w_dy_nxt      = r_dy;
    w_bx_nxt      = r_bx;
    w_blk_nxt     = r_blk;
    w_base_nxt    = r_base;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_acc_clr     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt   = S_READ;
          w_f4_nxt      = bus.factor_sel;
          w_dx_nxt      = 2'd0;
          w_dy_nxt      = 2'd0;
          w_bx_nxt      = '0;
          w_blk_nxt     = '0;
          w_base_nxt    = '0;
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = '0;
          w_acc_clr     = 1'b1;
        end
      end

      S_READ: begin
        if (r_dx == w_fm1) begin
          if (r_dy == w_fm1) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_dx_nxt      = 2'd0;
            w_dy_nxt      = r_dy + 2'd1;
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = r_rd_addr + w_row_step;
          end
        end else begin
          w_dx_nxt      = r_dx + 2'd1;
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end

      S_WAIT: begin
        w_state_nxt   = S_WRITE;
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_blk;
        w_wr_data_nxt = PIX_W'(r_f4 ? (w_acc_sum >> 4) : (w_acc_sum >> 2));
      end

      S_WRITE: begin
        w_acc_clr = 1'b1;
        if (r_blk == w_last_blk) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_READ;
          w_blk_nxt   = r_blk + ADDR_W'(1);
          w_dx_nxt    = 2'd0;
          w_dy_nxt    = 2'd0;
          if (r_bx == w_ow_m1) begin
            w_bx_nxt   = '0;
            w_base_nxt = r_base + w_brow_step;
          end else begin
            w_bx_nxt   = r_bx + ADDR_W'(1);
            w_base_nxt = r_base + w_f_step;
          end
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = w_base_nxt;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_READ) || (w_state_nxt == S_WAIT) ||
                 (w_state_nxt == S_WRITE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f4      <= 1'b0;
      r_dx      <= 2'd0;
      r_dy      <= 2'd0;
      r_bx      <= '0;
      r_blk     <= '0;
      r_base    <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_f4      <= w_f4_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_bx      <= w_bx_nxt;
      r_blk     <= w_blk_nxt;
      r_base    <= w_base_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_vld  <= r_rd_en;
      r_acc     <= w_acc_clr ? '0 : w_acc_sum;
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_block_average_scaler.sv
`default_nettype none
// ============================================================================
// tb_block_average_scaler: scoreboard bench for the block-average downscaler.
// Revision: 1.0
// ============================================================================
module tb_block_average_scaler;
  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_average_scaler_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  block_average_scaler #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [PIX_W-1:0] mem [0:IMG_W*IMG_H-1];

  // Source buffer with one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  wr_t               exp_wr [$];
  logic [ADDR_W-1:0] exp_rd [$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int overlap  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  wr_t               mon_wr;
  logic [ADDR_W-1:0] mon_rd;

  always @(negedge clk) begin
    if (bus.rd_en && bus.wr_en) overlap++;
    if (bus.rd_en && exp_rd.size() > 0) begin
      mon_rd = exp_rd.pop_front();
      check("rd_addr", int'(bus.rd_addr), int'(mon_rd));
    end
    if (bus.wr_en) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: got wr_addr=%0d, expected no write", bus.wr_addr);
      end else begin
        mon_wr = exp_wr.pop_front();
        check("wr_addr", int'(bus.wr_addr), int'(mon_wr.addr));
        check("wr_data", int'(bus.wr_data), int'(mon_wr.data));
      end
    end
  end

  function automatic void push_f2_expected();
    for (int i = 0; i < (IMG_W * IMG_H) / 4; i++) begin
      wr_t e;
      e.addr = ADDR_W'(i);
      e.data = (i == 0) ? 8'd254 : ((i == 1) ? 8'd0 : 8'd100);
      exp_wr.push_back(e);
    end
  endfunction

  function automatic void push_f4_expected();
    for (int i = 0; i < (IMG_W * IMG_H) / 16; i++) begin
      wr_t e;
      e.addr = ADDR_W'(i);
      e.data = ((i / 40) == 0) ? 8'd255 : PIX_W'(4 * (i % 40) + 1);
      exp_wr.push_back(e);
    end
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   int'(bus.rd_en),   0);
    check({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check({tag, "_wr_en"},   int'(bus.wr_en),   0);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_busy"},    int'(bus.busy),    0);
    check({tag, "_done"},    int'(bus.done),    0);
  endtask

  task automatic run_frame(input logic fsel, input int n_exp, input int cyc_exp,
                           input int poke_at);
    int k;
    bit seen;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.factor_sel = fsel;
    wr_cnt         = 0;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_rd_en", int'(bus.rd_en), 1);
    check("first_rd_addr", int'(bus.rd_addr), 0);
    check("first_busy", int'(bus.busy), 1);
    check("first_done", int'(bus.done), 0);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < cyc_exp + 100) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (k == poke_at) begin
          bus.start      = 1'b1;
          bus.factor_sel = ~fsel;
        end else if (k == poke_at + 1) begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    check("done_seen", int'(seen), 1);
    check("done_cycle", k, cyc_exp);
    check("busy_in_done", int'(bus.busy), 0);
    check("wr_en_in_done", int'(bus.wr_en), 0);
    check("wr_count", wr_cnt, n_exp);
    check("exp_queue_left", exp_wr.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.factor_sel = 1'b0;
    for (int a = 0; a < IMG_W * IMG_H; a++) mem[a] = 8'd100;
    mem[0]   = 8'd255; mem[1]   = 8'd255; mem[160] = 8'd255; mem[161] = 8'd254;
    mem[2]   = 8'd0;   mem[3]   = 8'd0;   mem[162] = 8'd0;   mem[163] = 8'd3;

    repeat (3) @(negedge clk);
    check_outputs_zero("por");
    reset = 1'b0;

    // Frame aborted by reset after write index 100
    exp_rd.push_back(16'd0);   exp_rd.push_back(16'd1);
    exp_rd.push_back(16'd160); exp_rd.push_back(16'd161);
    push_f2_expected();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.factor_sel = 1'b0;
    wr_cnt         = 0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (wr_cnt < 101 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("abort_wr_cnt", wr_cnt, 101);
    reset = 1'b1;
    @(negedge clk);
    exp_wr.delete();
    exp_rd.delete();
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
    check("idle_rd_en", int'(bus.rd_en), 0);

    // Full 2x2 frame with a mid-frame start pulse and factor_sel toggle
    exp_rd.push_back(16'd0);   exp_rd.push_back(16'd1);
    exp_rd.push_back(16'd160); exp_rd.push_back(16'd161);
    exp_rd.push_back(16'd2);   exp_rd.push_back(16'd3);
    exp_rd.push_back(16'd162); exp_rd.push_back(16'd163);
    push_f2_expected();
    run_frame(1'b0, 4800, 28801, 1000);

    // 4x4 frame started from DONE: top block row 255, the rest column index
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        mem[y * IMG_W + x] = (y < 4) ? 8'd255 : PIX_W'(x);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        exp_rd.push_back(ADDR_W'(dy * IMG_W + dx));
    push_f4_expected();
    run_frame(1'b1, 1200, 21601, -10);

    check("rd_wr_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
